// File: rtl/pipeline_trace_tracker.sv
// Instruction-lifetime tracker: shadows an N-stage pipeline, tags each fetch with a
// wrapping sequence ID and emits one retire record per instruction through a FWFT FIFO.
module pipeline_trace_tracker #(
  parameter int NUM_STAGES = 5,
  parameter int ID_W       = 7,
  parameter int DATA_W     = 16,
  parameter int CYC_W      = 32,
  parameter int STALL_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_valid,
  input  logic [DATA_W-1:0]     fetch_data,
  input  logic [NUM_STAGES-1:0] stall_vec,
  input  logic [NUM_STAGES-1:0] flush_vec,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [ID_W-1:0]       rec_id,
  output logic [DATA_W-1:0]     rec_data,
  output logic [CYC_W-1:0]      rec_fetch_cyc,
  output logic [CYC_W-1:0]      rec_retire_cyc,
  output logic [STALL_W-1:0]    rec_stall_cnt,
  output logic                  rec_flushed,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  overflow,
  output logic [CYC_W-1:0]      cycle_count
);

  localparam int LAST  = NUM_STAGES - 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [ID_W-1:0]       next_id_q, next_id_d;
  logic [CYC_W-1:0]      cycle_count_q, cycle_count_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;

  logic [ID_W-1:0]       id_q    [NUM_STAGES];
  logic [ID_W-1:0]       id_d    [NUM_STAGES];
  logic [DATA_W-1:0]     data_q  [NUM_STAGES];
  logic [DATA_W-1:0]     data_d  [NUM_STAGES];
  logic [CYC_W-1:0]      fcyc_q  [NUM_STAGES];
  logic [CYC_W-1:0]      fcyc_d  [NUM_STAGES];
  logic [STALL_W-1:0]    stall_q [NUM_STAGES];
  logic [STALL_W-1:0]    stall_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] flushed_q, flushed_d;

  logic [ID_W-1:0]       mem_id_q    [FIFO_DEPTH];
  logic [ID_W-1:0]       mem_id_d    [FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_data_q  [FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_data_d  [FIFO_DEPTH];
  logic [CYC_W-1:0]      mem_fcyc_q  [FIFO_DEPTH];
  logic [CYC_W-1:0]      mem_fcyc_d  [FIFO_DEPTH];
  logic [CYC_W-1:0]      mem_rcyc_q  [FIFO_DEPTH];
  logic [CYC_W-1:0]      mem_rcyc_d  [FIFO_DEPTH];
  logic [STALL_W-1:0]    mem_stall_q [FIFO_DEPTH];
  logic [STALL_W-1:0]    mem_stall_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_fl_q, mem_fl_d;

  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] flushed_eff;
  logic                  retire, empty, full, pop, push;
  logic [PTR_W-1:0]      wr_idx, rd_idx;

  // A stall in stage i freezes every younger stage as well.
  always_comb begin : hold_calc
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = LAST; i >= 0; i--) begin
      acc     = acc | stall_vec[i];
      hold[i] = acc;
    end
  end

  // Flush marks whatever register the instruction lands in after this edge.
  assign flushed_eff = flushed_q | (flush_vec & valid_q);

  always_comb begin : stage_next
    valid_d   = valid_q;
    flushed_d = flushed_q;
    id_d      = id_q;
    data_d    = data_q;
    fcyc_d    = fcyc_q;
    stall_d   = stall_q;
    if (hold[0]) begin
      flushed_d[0] = flushed_eff[0];
      if (valid_q[0]) stall_d[0] = sat_inc(stall_q[0]);
    end else begin
      valid_d[0]   = fetch_valid;
      id_d[0]      = next_id_q;
      data_d[0]    = fetch_data;
      fcyc_d[0]    = cycle_count_q;
      stall_d[0]   = '0;
      flushed_d[0] = 1'b0;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (hold[i]) begin
        flushed_d[i] = flushed_eff[i];
        if (valid_q[i]) stall_d[i] = sat_inc(stall_q[i]);
      end else if (hold[i-1]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i]   = valid_q[i-1];
        id_d[i]      = id_q[i-1];
        data_d[i]    = data_q[i-1];
        fcyc_d[i]    = fcyc_q[i-1];
        stall_d[i]   = stall_q[i-1];
        flushed_d[i] = flushed_eff[i-1];
      end
    end
  end

  assign next_id_d     = next_id_q + ID_W'(fetch_valid & ~hold[0]);
  assign cycle_count_d = cycle_count_q + 1'b1;

  assign retire = valid_q[LAST] & ~stall_vec[LAST];
  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
  assign pop    = ~empty & rec_ready;
  // When full, a same-edge pop frees the head slot that the push overwrites.
  assign push   = retire & (~full | pop);

  assign wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push);
  assign rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
  assign overflow_d = overflow_q | (retire & full & ~pop);

  always_comb begin : fifo_next
    mem_id_d    = mem_id_q;
    mem_data_d  = mem_data_q;
    mem_fcyc_d  = mem_fcyc_q;
    mem_rcyc_d  = mem_rcyc_q;
    mem_stall_d = mem_stall_q;
    mem_fl_d    = mem_fl_q;
    if (push) begin
      mem_id_d[wr_idx]    = id_q[LAST];
      mem_data_d[wr_idx]  = data_q[LAST];
      mem_fcyc_d[wr_idx]  = fcyc_q[LAST];
      mem_rcyc_d[wr_idx]  = cycle_count_q;
      mem_stall_d[wr_idx] = stall_q[LAST];
      mem_fl_d[wr_idx]    = flushed_eff[LAST];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      next_id_q     <= '0;
      cycle_count_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      next_id_q     <= next_id_d;
      cycle_count_q <= cycle_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
    end
  end

  // Payload is only meaningful under a valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    id_q        <= id_d;
    data_q      <= data_d;
    fcyc_q      <= fcyc_d;
    stall_q     <= stall_d;
    flushed_q   <= flushed_d;
    mem_id_q    <= mem_id_d;
    mem_data_q  <= mem_data_d;
    mem_fcyc_q  <= mem_fcyc_d;
    mem_rcyc_q  <= mem_rcyc_d;
    mem_stall_q <= mem_stall_d;
    mem_fl_q    <= mem_fl_d;
  end

  assign rec_valid      = ~empty;
  assign rec_id         = rec_valid ? mem_id_q[rd_idx]    : '0;
  assign rec_data       = rec_valid ? mem_data_q[rd_idx]  : '0;
  assign rec_fetch_cyc  = rec_valid ? mem_fcyc_q[rd_idx]  : '0;
  assign rec_retire_cyc = rec_valid ? mem_rcyc_q[rd_idx]  : '0;
  assign rec_stall_cnt  = rec_valid ? mem_stall_q[rd_idx] : '0;
  assign rec_flushed    = rec_valid & mem_fl_q[rd_idx];
  assign stage_valid    = valid_q;
  assign overflow       = overflow_q;
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_pipeline_trace_tracker.sv
// Bench for pipeline_trace_tracker: instruction-level reference model compared every
// cycle, plus directed scenarios with hand-computed record expectations.
module tb_pipeline_trace_tracker;
  localparam int NS = 5, FD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_data = '0;
  logic [4:0]  stall_vec = '0, flush_vec = '0;
  logic        rec_ready = 1'b1;

  logic        rec_valid, rec_flushed, overflow;
  logic [6:0]  rec_id;
  logic [15:0] rec_data;
  logic [31:0] rec_fetch_cyc, rec_retire_cyc, cycle_count;
  logic [7:0]  rec_stall_cnt;
  logic [4:0]  stage_valid;

  logic        b_valid, b_flushed, b_overflow;
  logic [2:0]  b_id;
  logic [15:0] b_data;
  logic [31:0] b_fcyc, b_rcyc, b_cc;
  logic [7:0]  b_stall;
  logic [4:0]  b_sv;

  pipeline_trace_tracker dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .stall_vec(stall_vec), .flush_vec(flush_vec), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_id(rec_id), .rec_data(rec_data), .rec_fetch_cyc(rec_fetch_cyc),
    .rec_retire_cyc(rec_retire_cyc), .rec_stall_cnt(rec_stall_cnt), .rec_flushed(rec_flushed),
    .stage_valid(stage_valid), .overflow(overflow), .cycle_count(cycle_count));

  pipeline_trace_tracker #(.ID_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .stall_vec(stall_vec), .flush_vec(flush_vec), .rec_valid(b_valid), .rec_ready(rec_ready),
    .rec_id(b_id), .rec_data(b_data), .rec_fetch_cyc(b_fcyc),
    .rec_retire_cyc(b_rcyc), .rec_stall_cnt(b_stall), .rec_flushed(b_flushed),
    .stage_valid(b_sv), .overflow(b_overflow), .cycle_count(b_cc));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit cmp_en = 0, cap_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of in-flight instructions, each knowing its stage.
  typedef struct { int id; logic [15:0] data; logic [31:0] fcyc; int stall; bit fl; int pos; } ins_t;
  typedef struct { int id; logic [15:0] data; logic [31:0] fcyc; logic [31:0] rcyc; int stall; bit fl; } rec_t;
  ins_t        pipe[$];
  rec_t        mq[$];
  int          m_next_id;
  logic [31:0] m_cc;
  bit          m_ovf;

  function automatic void model_reset();
    pipe.delete();
    mq.delete();
    m_next_id = 0;
    m_cc = '0;
    m_ovf = 0;
  endfunction

  function automatic void model_step();
    bit   h[NS];
    bit   acc;
    ins_t nxt[$];
    ins_t p;
    rec_t r;
    acc = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      acc = acc | stall_vec[i];
      h[i] = acc;
    end
    if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
    foreach (pipe[k]) begin
      p = pipe[k];
      if (flush_vec[p.pos]) p.fl = 1;
      if (h[p.pos]) begin
        if (p.stall < 255) p.stall++;
        nxt.push_back(p);
      end else if (p.pos == NS - 1) begin
        r.id = p.id; r.data = p.data; r.fcyc = p.fcyc; r.rcyc = m_cc;
        r.stall = p.stall; r.fl = p.fl;
        if (mq.size() < FD) mq.push_back(r);
        else m_ovf = 1;
      end else begin
        p.pos++;
        nxt.push_back(p);
      end
    end
    pipe = nxt;
    if (fetch_valid && !h[0]) begin
      p.id = m_next_id; p.data = fetch_data; p.fcyc = m_cc; p.stall = 0; p.fl = 0; p.pos = 0;
      pipe.push_back(p);
      m_next_id++;
    end
    m_cc++;
  endfunction

  always @(negedge clk) begin : compare
    logic [4:0] sv;
    if (cmp_en) begin
      sv = '0;
      foreach (pipe[k]) sv[pipe[k].pos] = 1'b1;
      chk("stage_valid", stage_valid, sv);
      chk("stage_valid3", b_sv, sv);
      chk("cycle_count", cycle_count, m_cc);
      chk("cycle_count3", b_cc, m_cc);
      chk("overflow", overflow, m_ovf);
      chk("overflow3", b_overflow, m_ovf);
      chk("rec_valid", rec_valid, mq.size() != 0);
      chk("rec_valid3", b_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("rec_id", rec_id, mq[0].id % 128);
        chk("rec_id3", b_id, mq[0].id % 8);
        chk("rec_data", rec_data, mq[0].data);
        chk("rec_data3", b_data, mq[0].data);
        chk("rec_fetch_cyc", rec_fetch_cyc, mq[0].fcyc);
        chk("rec_retire_cyc", rec_retire_cyc, mq[0].rcyc);
        chk("rec_stall_cnt", rec_stall_cnt, mq[0].stall);
        chk("rec_flushed", rec_flushed, mq[0].fl);
        chk("rec_fcyc3", b_fcyc, mq[0].fcyc);
        chk("rec_rcyc3", b_rcyc, mq[0].rcyc);
        chk("rec_stall3", b_stall, mq[0].stall);
        chk("rec_flushed3", b_flushed, mq[0].fl);
      end
    end
  end

  // Records accepted by the consumer, for the literal checks.
  int          got_n;
  logic [6:0]  g_id[32];
  logic [2:0]  g_id3[32];
  logic [15:0] g_data[32];
  logic [31:0] g_f[32], g_r[32];
  logic [7:0]  g_st[32];
  logic        g_fl[32];

  always @(negedge clk) begin
    if (cap_en && rec_valid && rec_ready) begin
      if (got_n < 32) begin
        g_id[got_n] = rec_id; g_id3[got_n] = b_id; g_data[got_n] = rec_data;
        g_f[got_n] = rec_fetch_cyc; g_r[got_n] = rec_retire_cyc;
        g_st[got_n] = rec_stall_cnt; g_fl[got_n] = rec_flushed;
      end
      got_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    got_n = 0;
    cap_en = 1;
  endtask

  task automatic fetch_n(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      fetch_valid = 1'b1;
      fetch_data = base + 16'(k);
      tick();
    end
    fetch_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_rec_data", rec_data, 0);
    cmp_en = 1;

    // single instruction fetched at cycle 3
    do_reset();
    repeat (3) tick();
    fetch_valid = 1'b1; fetch_data = 16'hA123;
    tick();
    fetch_valid = 1'b0;
    repeat (10) tick();
    chk("t1_count", got_n, 1);
    chk("t1_id", g_id[0], 0);
    chk("t1_data", g_data[0], 16'hA123);
    chk("t1_fcyc", g_f[0], 3);
    chk("t1_rcyc", g_r[0], 8);
    chk("t1_stall", g_st[0], 0);
    chk("t1_flushed", g_fl[0], 0);

    // four back-to-back fetches
    do_reset();
    fetch_n(4, 16'h1000);
    repeat (8) tick();
    chk("t2_count", got_n, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_id", g_id[k], k);
      chk("t2_fcyc", g_f[k], k);
      chk("t2_lat", g_r[k] - g_f[k], 5);
    end

    // stall stage 2 for two cycles with A in stage 2, B in stage 1
    do_reset();
    fetch_n(2, 16'h00A0);
    tick();
    stall_vec = 5'b00100; fetch_valid = 1'b1; fetch_data = 16'h0CCC;
    tick();
    tick();
    stall_vec = '0; fetch_data = 16'h0DDD;
    tick();
    fetch_valid = 1'b0;
    repeat (10) tick();
    chk("t3_count", got_n, 3);
    chk("t3_a_id", g_id[0], 0);
    chk("t3_a_stall", g_st[0], 2);
    chk("t3_a_lat", g_r[0] - g_f[0], 7);
    chk("t3_b_id", g_id[1], 1);
    chk("t3_b_stall", g_st[1], 2);
    chk("t3_b_lat", g_r[1] - g_f[1], 7);
    chk("t3_d_id", g_id[2], 2);
    chk("t3_d_data", g_data[2], 16'h0DDD);
    chk("t3_d_rcyc", g_r[2], 10);

    // flush on stage 1 (occupied), then on stage 3 (empty)
    do_reset();
    fetch_n(2, 16'h0E00);
    flush_vec = 5'b00010;
    tick();
    flush_vec = 5'b01000;
    tick();
    flush_vec = '0;
    repeat (8) tick();
    chk("t4_count", got_n, 2);
    chk("t4_e_id", g_id[0], 0);
    chk("t4_e_data", g_data[0], 16'h0E00);
    chk("t4_e_flushed", g_fl[0], 1);
    chk("t4_f_id", g_id[1], 1);
    chk("t4_f_flushed", g_fl[1], 0);

    // consumer stalled: the fifth retire overflows
    do_reset();
    rec_ready = 1'b0;
    fetch_n(6, 16'h0500);
    repeat (3) tick();
    chk("t5_ovf_before", overflow, 0);
    tick();
    chk("t5_ovf_after", overflow, 1);
    repeat (2) tick();
    got_n = 0;
    rec_ready = 1'b1;
    repeat (8) tick();
    chk("t5_count", got_n, 4);
    for (int k = 0; k < 4; k++) chk("t5_id", g_id[k], k);
    chk("t5_ovf_sticky", overflow, 1);
    chk("t5_drained", rec_valid, 0);

    // narrow IDs wrap
    do_reset();
    fetch_n(10, 16'h0300);
    repeat (8) tick();
    chk("t6_count", got_n, 10);
    for (int k = 0; k < 10; k++) chk("t6_id3", g_id3[k], k % 8);
    chk("t6_id7_last", g_id[9], 9);

    // asynchronous reset mid-stream
    do_reset();
    rec_ready = 1'b0;
    fetch_n(8, 16'h0700);
    repeat (2) tick();
    chk("t7_pre_valid", rec_valid, 1);
    chk("t7_pre_ovf", overflow, 1);
    chk("t7_pre_busy", stage_valid != 0, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7_sv", stage_valid, 0);
    chk("t7_rec_valid", rec_valid, 0);
    chk("t7_ovf", overflow, 0);
    chk("t7_cc", cycle_count, 0);
    chk("t7_rec_valid3", b_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    rec_ready = 1'b1;
    got_n = 0;
    repeat (12) tick();
    chk("t7_no_records", got_n, 0);
    chk("t7_sv_empty", stage_valid, 0);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
